// File: rtl/ssd_share_arbiter.sv
// ssd_share_arbiter: two requesters share one 4-digit multiplexed 7-segment display with dwell-based fairness.
// Define SSD_LEADING_ZERO_BLANK_EN to blank digits above the most significant non-zero nibble.
module ssd_share_arbiter #(
    parameter int SCAN_DIV = 1250,
    parameter int DWELL    = 64
) (
    input  logic        x1,
    input  logic        rstN,
    input  logic        reqA,
    input  logic [15:0] dataA,
    input  logic        reqB,
    input  logic [15:0] dataB,
    output logic        gntA,
    output logic        gntB,
    output logic [3:0]  anodes,
    output logic [7:0]  SSD
);
    localparam int DW = $clog2(SCAN_DIV > 1 ? SCAN_DIV : 2);
    localparam int WW = $clog2(DWELL + 2);
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt;
    logic [1:0]    digit;
    logic [WW-1:0] dwell;
    logic          last_b;
    logic          tick, frame_end, dwell_met, clear;
    logic [15:0]   data;
    logic [3:0]    nib;
    logic          lead_zero, shown;

    assign tick      = div_cnt == DW'(SCAN_DIV - 1);
    assign frame_end = tick && digit == 2'd3;
    // counts the frame ending this cycle, so the hand-over lands on the DWELL-th frame end
    assign dwell_met = int'(dwell) + 1 >= DWELL;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (reqA && (!reqB || last_b)) ? OWN_A : reqB ? OWN_B : IDLE;
            OWN_A:   state_nx = !reqA ? (reqB ? OWN_B : IDLE) : (reqB && frame_end && dwell_met) ? OWN_B : OWN_A;
            OWN_B:   state_nx = !reqB ? (reqA ? OWN_A : IDLE) : (reqA && frame_end && dwell_met) ? OWN_A : OWN_B;
            default: state_nx = IDLE;
        endcase
    end

    assign clear = state_nx != state || state == IDLE;
    assign gntA  = state == OWN_A;
    assign gntB  = state == OWN_B;
    assign data  = state == OWN_B ? dataB : dataA;
    assign nib   = data[{digit, 2'b00} +: 4];

`ifdef SSD_LEADING_ZERO_BLANK_EN
    assign lead_zero = digit == 2'd3 ? data[15:12] == 4'h0 :
                       digit == 2'd2 ? data[15:8] == 8'h0 :
                       digit == 2'd1 ? data[15:4] == 12'h0 : 1'b0;
`else
    assign lead_zero = 1'b0;
`endif

    assign shown = state != IDLE && !lead_zero;

    always_ff @(posedge x1 or negedge rstN) begin
        if (!rstN) begin
            state   <= IDLE;
            div_cnt <= '0;
            digit   <= '0;
            dwell   <= '0;
            last_b  <= 1'b1;
            anodes  <= 4'hF;
            SSD     <= 8'hFF;
        end else begin
            state <= state_nx;
            if (clear) begin
                div_cnt <= '0;
                digit   <= '0;
                dwell   <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) digit <= digit + 2'd1;
                if (frame_end && int'(dwell) < DWELL) dwell <= dwell + 1'b1;
            end
            if (state_nx != state && state_nx != IDLE) last_b <= state_nx == OWN_B;
            anodes <= shown ? ~(4'b0001 << digit) : 4'hF;
            SSD    <= shown ? SEG[nib] : 8'hFF;
        end
    end
endmodule

// File: tb/tb_ssd_share_arbiter.sv
// tb_ssd_share_arbiter: directed literal checks plus randomized traffic against a behavioural ownership model.
module tb_ssd_share_arbiter;
    localparam int SD = 4;
    localparam int DWL = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        reqA = 1'b0, reqB = 1'b0;
    logic [15:0] dataA = '0, dataB = '0;
    logic        gntA, gntB;
    logic [3:0]  anodes;
    logic [7:0]  SSD;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] enc [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    ssd_share_arbiter #(.SCAN_DIV(SD), .DWELL(DWL)) dut (
        .x1(clk), .rstN(rstN), .reqA(reqA), .dataA(dataA), .reqB(reqB), .dataB(dataB),
        .gntA(gntA), .gntB(gntB), .anodes(anodes), .SSD(SSD)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // model: owner 0=none 1=A 2=B, t = cycles spent with the current owner
    int          m_own = 0, m_t = 0, nxt, d;
    logic        m_lastb = 1'b1, mine, other;
    logic [3:0]  m_an = 4'hF;
    logic [7:0]  m_seg = 8'hFF;
    logic [15:0] v;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_own = 0; m_t = 0; m_lastb = 1'b1; m_an = 4'hF; m_seg = 8'hFF;
        end else begin
            if (m_own == 0) begin
                m_an = 4'hF; m_seg = 8'hFF;
            end else begin
                d = (m_t / SD) % 4;
                v = m_own == 1 ? dataA : dataB;
                m_an = 4'hF ^ (4'b0001 << d);
                m_seg = enc[(v >> (4 * d)) & 16'hF];
`ifdef SSD_LEADING_ZERO_BLANK_EN
                if (d > 0 && (v >> (4 * d)) == 16'h0) begin
                    m_an = 4'hF; m_seg = 8'hFF;
                end
`endif
            end
            nxt = m_own;
            if (m_own == 0) begin
                if (reqA && reqB) nxt = m_lastb ? 1 : 2;
                else if (reqA) nxt = 1;
                else if (reqB) nxt = 2;
            end else begin
                mine  = m_own == 1 ? reqA : reqB;
                other = m_own == 1 ? reqB : reqA;
                if (!mine) nxt = other ? 3 - m_own : 0;
                else if (other && m_t % FRAME == FRAME - 1 && (m_t + 1) / FRAME >= DWL) nxt = 3 - m_own;
            end
            if (nxt != m_own) begin
                m_t = 0;
                if (nxt != 0) m_lastb = nxt == 2;
            end else if (m_own != 0) m_t++;
            m_own = nxt;
        end
    end

    always @(negedge clk) begin
        check("gntA", 32'(gntA), (m_own == 1) ? 1 : 0);
        check("gntB", 32'(gntB), (m_own == 2) ? 1 : 0);
        check("anodes", 32'(anodes), 32'(m_an));
        check("SSD", 32'(SSD), 32'(m_seg));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    int rate = 20;

    initial begin
        #1 rstN = 1'b0;
        step(2);
        check("reset_an", 32'(anodes), 32'hF);
        check("reset_ssd", 32'(SSD), 32'hFF);
        check("reset_gnt", 32'({gntA, gntB}), 0);
        reqA = 1'b1; dataA = 16'h12AF; rstN = 1'b1;
        step(1);
        check("first_gntA", 32'({gntA, gntB}), 2);
        check("entry_an_blank", 32'(anodes), 32'hF);
        step(1);
        check("d0_an", 32'(anodes), 32'hE);
        check("d0_ssd", 32'(SSD), 32'h8E);
        reqB = 1'b1;
        step(4);
        check("d1_an", 32'(anodes), 32'hD);
        check("d1_ssd", 32'(SSD), 32'h88);
        step(4);
        check("d2_an", 32'(anodes), 32'hB);
        check("d2_ssd", 32'(SSD), 32'hA4);
        step(4);
        check("d3_an", 32'(anodes), 32'h7);
        check("d3_ssd", 32'(SSD), 32'hF9);
        step(4);
        check("wrap_an", 32'(anodes), 32'hE);
        check("wrap_ssd", 32'(SSD), 32'h8E);
        step(14);
        check("dwell_hold_A", 32'({gntA, gntB}), 2);
        step(1);
        check("dwell_switch_B", 32'({gntA, gntB}), 1);
        reqB = 1'b0;
        step(1);
        check("drop_to_A", 32'({gntA, gntB}), 2);
        reqA = 1'b0;
        step(1);
        check("drop_idle", 32'({gntA, gntB}), 0);
        step(1);
        check("idle_an", 32'(anodes), 32'hF);
        check("idle_ssd", 32'(SSD), 32'hFF);
        reqA = 1'b1; reqB = 1'b1;
        step(1);
        check("tie_last_A_gives_B", 32'({gntA, gntB}), 1);
        step(6);
        #1 rstN = 1'b0;
        #1;
        check("async_rst_gnt", 32'({gntA, gntB}), 0);
        check("async_rst_an", 32'(anodes), 32'hF);
        check("async_rst_ssd", 32'(SSD), 32'hFF);
        dataB = 16'h0005;
        @(posedge clk);
        #2 rstN = 1'b1;
        step(1);
        check("tie_after_reset_A", 32'({gntA, gntB}), 2);
        reqA = 1'b0;
        step(1);
        check("handover_B", 32'({gntA, gntB}), 1);
        step(1);
        check("b_d0_an", 32'(anodes), 32'hE);
        check("b_d0_ssd", 32'(SSD), 32'h92);
        step(4);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        check("b_d1_an", 32'(anodes), 32'hF);
        check("b_d1_ssd", 32'(SSD), 32'hFF);
`else
        check("b_d1_an", 32'(anodes), 32'hD);
        check("b_d1_ssd", 32'(SSD), 32'hC0);
`endif
        dataB = 16'h0000;
        step(12);
        check("b_zero_an", 32'(anodes), 32'hE);
        check("b_zero_ssd", 32'(SSD), 32'hC0);
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) rate = $urandom_range(2, 60);
            if ($urandom_range(0, rate - 1) == 0) reqA = ~reqA;
            if ($urandom_range(0, rate - 1) == 0) reqB = ~reqB;
            if ($urandom_range(0, 15) == 0) dataA = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) dataB = 16'($urandom) >> (4 * $urandom_range(0, 4));
            if ($urandom_range(0, 399) == 0) begin
                #1 rstN = 1'b0;
                @(posedge clk);
                #2 rstN = 1'b1;
            end
            step(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
